sitcpxg_tx_arbiter: RTL and testbench

//  Shares the single SiTCPXG TCP transmit port (64-bit TX_D / 4-bit TX_B) among NUM_REQ

---
 rtl/sitcpxg_pkg.sv | 18 +
 rtl/sitcpxg_rr_pick.sv | 30 +++
 rtl/sitcpxg_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_sitcpxg_tx_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sitcpxg_pkg.sv
// Shared constants, arbiter state type and byte-count helper for the SiTCPXG TX arbiter.
package sitcpxg_pkg;

  localparam int TX_DW        = 64;
  localparam int TX_BW        = 4;
  localparam int TX_MAX_BYTES = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  // A requester may report more bytes than a word holds; the SiTCPXG port only takes up to 8.
  function automatic logic [TX_BW-1:0] clamp_bytes(input logic [TX_BW-1:0] b);
    return (b > TX_BW'(TX_MAX_BYTES)) ? TX_BW'(TX_MAX_BYTES) : b;
  endfunction

endpackage

// File: rtl/sitcpxg_rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after last_idx, wrapping.
module sitcpxg_rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_idx,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic found;
  int   c;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(last_idx) + k) % N;
      if (!found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = IW'(c);
      end
    end
  end

endmodule

// File: rtl/sitcpxg_tx_arbiter.sv
// Round-robin, burst-granular arbiter sharing the SiTCPXG TCP transmit port among NUM_REQ sources.
// Optional per-requester word and stall counters are built when SITCPXG_TX_ARB_STATS_EN is defined.
//
// state | meaning
// IDLE  | no owner; pick next requester when link is up, buffer has room and someone is valid
// XFER  | GRANT owner streams words until LAST, MAX_BURST words, or connection loss
module sitcpxg_tx_arbiter
  import sitcpxg_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int MAX_BURST = 256
) (
  input  logic                     CLK156M,
  input  logic                     RSTn,
  input  logic                     ESTABLISHED,
  input  logic                     TX_AFULL,
  input  logic [NUM_REQ-1:0]       REQ_VALID,
  input  logic [NUM_REQ-1:0]       REQ_LAST,
  input  logic [NUM_REQ*TX_DW-1:0] REQ_DATA,
  input  logic [NUM_REQ*TX_BW-1:0] REQ_BYTES,
  output logic [NUM_REQ-1:0]       REQ_READY,
  output logic [NUM_REQ-1:0]       GRANT,
  output logic [TX_DW-1:0]         TX_D,
  output logic [TX_BW-1:0]         TX_B
`ifdef SITCPXG_TX_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]    STAT_WORDS,
  output logic [31:0]              STAT_STALL
`endif
);

  localparam int IW  = $clog2(NUM_REQ);
  localparam int BCW = $clog2(MAX_BURST + 1);

  arb_state_t         state, state_nx;
  logic [NUM_REQ-1:0] grant_nx, pick_grant;
  logic [IW-1:0]      gidx, gidx_nx, rr_ptr, rr_ptr_nx, pick_idx;
  logic [BCW-1:0]     burst_cnt, burst_cnt_nx;
  logic               go, xfer, burst_end;
  logic               sel_valid, sel_last;
  logic [TX_DW-1:0]   sel_data;
  logic [TX_BW-1:0]   sel_bytes;

  sitcpxg_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req      (REQ_VALID),
    .last_idx (rr_ptr),
    .grant    (pick_grant),
    .idx      (pick_idx)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_bytes = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx == IW'(i)) begin
        sel_valid = REQ_VALID[i];
        sel_last  = REQ_LAST[i];
        sel_data  = REQ_DATA[TX_DW*i +: TX_DW];
        sel_bytes = REQ_BYTES[TX_BW*i +: TX_BW];
      end
    end
  end

  assign go        = ESTABLISHED & ~TX_AFULL;
  assign xfer      = (state == XFER) & go & sel_valid;
  assign burst_end = (burst_cnt == BCW'(MAX_BURST - 1));
  assign REQ_READY = ((state == XFER) && go) ? GRANT : '0;

  always_comb begin
    state_nx     = state;
    grant_nx     = GRANT;
    gidx_nx      = gidx;
    rr_ptr_nx    = rr_ptr;
    burst_cnt_nx = burst_cnt;
    case (state)
      IDLE: begin
        if (go && |REQ_VALID) begin
          state_nx     = XFER;
          grant_nx     = pick_grant;
          gidx_nx      = pick_idx;
          burst_cnt_nx = '0;
        end
      end
      XFER: begin
        // Connection loss keeps rr_ptr so the interrupted owner is first on reconnect.
        if (!ESTABLISHED) begin
          state_nx = IDLE;
          grant_nx = '0;
        end else if (xfer) begin
          burst_cnt_nx = burst_cnt + 1'b1;
          if (sel_last || burst_end) begin
            state_nx  = IDLE;
            grant_nx  = '0;
            rr_ptr_nx = gidx;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
      end
    endcase
  end

  always_ff @(posedge CLK156M or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      GRANT     <= '0;
      gidx      <= '0;
      rr_ptr    <= IW'(NUM_REQ - 1);
      burst_cnt <= '0;
    end else begin
      state     <= state_nx;
      GRANT     <= grant_nx;
      gidx      <= gidx_nx;
      rr_ptr    <= rr_ptr_nx;
      burst_cnt <= burst_cnt_nx;
    end
  end

  always_ff @(posedge CLK156M or negedge RSTn) begin
    if (!RSTn) begin
      TX_D <= '0;
      TX_B <= '0;
    end else if (xfer) begin
      TX_D <= sel_data;
      TX_B <= clamp_bytes(sel_bytes);
    end else begin
      TX_B <= '0;
    end
  end

`ifdef SITCPXG_TX_ARB_STATS_EN
  always_ff @(posedge CLK156M or negedge RSTn) begin
    if (!RSTn) begin
      STAT_WORDS <= '0;
      STAT_STALL <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (xfer && gidx == IW'(i))
          STAT_WORDS[32*i +: 32] <= STAT_WORDS[32*i +: 32] + 32'd1;
      end
      if (state == XFER && TX_AFULL && STAT_STALL != 32'hFFFF_FFFF)
        STAT_STALL <= STAT_STALL + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sitcpxg_tx_arbiter.sv
// Directed bench for sitcpxg_tx_arbiter (NUM_REQ=3, MAX_BURST=4) with per-cycle output logging.
module tb_sitcpxg_tx_arbiter;

  localparam int N  = 3;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           est = 1'b0;
  logic           afull = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last = '0;
  logic [N*64-1:0] req_data = '0;
  logic [N*4-1:0] req_bytes = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic [63:0]    tx_d;
  logic [3:0]     tx_b;

  sitcpxg_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
    .CLK156M     (clk),
    .RSTn        (rst_n),
    .ESTABLISHED (est),
    .TX_AFULL    (afull),
    .REQ_VALID   (req_valid),
    .REQ_LAST    (req_last),
    .REQ_DATA    (req_data),
    .REQ_BYTES   (req_bytes),
    .REQ_READY   (req_ready),
    .GRANT       (grant),
    .TX_D        (tx_d),
    .TX_B        (tx_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] s_data  [N][16];
  logic [3:0]  s_bytes [N][16];
  logic        s_last  [N][16];
  int          s_len   [N];
  int          s_pos   [N];

  logic [3:0]   log_b [64];
  logic [63:0]  log_d [64];
  logic [N-1:0] log_g [64];
  logic [N-1:0] log_r [64];
  int           cyc;

  function automatic logic [63:0] wd(input int s, input int i);
    return 64'hD0D0_0000_0000_0000 | (64'(s) << 16) | 64'(i);
  endfunction

  task automatic load(input int s, input int n, input int last_mask, input logic [3:0] b);
    s_len[s] = n;
    s_pos[s] = 0;
    for (int i = 0; i < n; i++) begin
      s_data[s][i]  = wd(s, i);
      s_bytes[s][i] = b;
      s_last[s][i]  = last_mask[i];
    end
  endtask

  task automatic drive_sources();
    for (int s = 0; s < N; s++) begin
      if (s_pos[s] < s_len[s]) begin
        req_valid[s]          = 1'b1;
        req_last[s]           = s_last[s][s_pos[s]];
        req_data[64*s +: 64]  = s_data[s][s_pos[s]];
        req_bytes[4*s +: 4]   = s_bytes[s][s_pos[s]];
      end else begin
        req_valid[s]          = 1'b0;
        req_last[s]           = 1'b0;
        req_data[64*s +: 64]  = '0;
        req_bytes[4*s +: 4]   = '0;
      end
    end
  endtask

  // One clock: drive, sample READY/GRANT before the edge, sample TX after it.
  task automatic tick(input logic e, input logic a);
    logic [N-1:0] acc;
    est   = e;
    afull = a;
    drive_sources();
    #1;
    log_r[cyc] = req_ready;
    log_g[cyc] = grant;
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    log_b[cyc] = tx_b;
    log_d[cyc] = tx_d;
    for (int s = 0; s < N; s++)
      if (acc[s]) s_pos[s]++;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int t = 0; t < n; t++) tick(1'b1, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    est   = 1'b1;
    afull = 1'b0;
    for (int s = 0; s < N; s++) begin
      s_len[s] = 0;
      s_pos[s] = 0;
    end
    drive_sources();
    cyc = 0;
    #12;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    est       = 1'b1;
    req_valid = 3'b111;
    #3;
    n_checks++; if (grant !== 3'b000) $display("FAIL reset_grant got=%b exp=000", grant); else n_pass++;
    n_checks++; if (req_ready !== 3'b000) $display("FAIL reset_ready got=%b exp=000", req_ready); else n_pass++;
    n_checks++; if (tx_b !== 4'd0) $display("FAIL reset_tx_b got=%0d exp=0", tx_b); else n_pass++;
    n_checks++; if (tx_d !== 64'd0) $display("FAIL reset_tx_d got=%h exp=0", tx_d); else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    load(0, 4, 'b1000, 4'd8);
    for (int t = 0; t < 6; t++) tick(1'b1, 1'b0);
    n_checks++; if (log_r[0] !== 3'b000) $display("FAIL single_ready_idle got=%b exp=000", log_r[0]); else n_pass++;
    n_checks++; if (log_g[1] !== 3'b001) $display("FAIL single_grant got=%b exp=001", log_g[1]); else n_pass++;
    for (int k = 1; k <= 4; k++) begin
      n_checks++; if (log_r[k] !== 3'b001) $display("FAIL single_ready c%0d got=%b exp=001", k, log_r[k]); else n_pass++;
      n_checks++; if (log_b[k] !== 4'd8) $display("FAIL single_tx_b c%0d got=%0d exp=8", k, log_b[k]); else n_pass++;
      n_checks++; if (log_d[k] !== wd(0, k-1)) $display("FAIL single_tx_d c%0d got=%h exp=%h", k, log_d[k], wd(0, k-1)); else n_pass++;
    end
    n_checks++; if (log_g[5] !== 3'b000) $display("FAIL single_grant_end got=%b exp=000", log_g[5]); else n_pass++;
    n_checks++; if (log_b[5] !== 4'd0) $display("FAIL single_tx_b_end got=%0d exp=0", log_b[5]); else n_pass++;
    n_checks++; if (log_d[5] !== wd(0, 3)) $display("FAIL single_tx_d_hold got=%h exp=%h", log_d[5], wd(0, 3)); else n_pass++;
  endtask

  task automatic test_rr_fairness();
    int           gc [4] = '{1, 4, 7, 10};
    logic [N-1:0] gv [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    int           oc [8] = '{1, 2, 4, 5, 7, 8, 10, 11};
    int           os [8] = '{0, 0, 1, 1, 2, 2, 0, 0};
    int           oi [8] = '{0, 1, 0, 1, 0, 1, 2, 3};
    int           zc [4] = '{3, 6, 9, 12};
    do_reset();
    load(0, 4, 'b1010, 4'd8);
    load(1, 2, 'b10, 4'd8);
    load(2, 2, 'b10, 4'd8);
    run(13);
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (log_g[gc[k]] !== gv[k]) $display("FAIL rr_grant #%0d got=%b exp=%b", k, log_g[gc[k]], gv[k]); else n_pass++;
    end
    for (int k = 0; k < 8; k++) begin
      n_checks++; if (log_b[oc[k]] !== 4'd8) $display("FAIL rr_tx_b c%0d got=%0d exp=8", oc[k], log_b[oc[k]]); else n_pass++;
      n_checks++; if (log_d[oc[k]] !== wd(os[k], oi[k])) $display("FAIL rr_tx_d c%0d got=%h exp=%h", oc[k], log_d[oc[k]], wd(os[k], oi[k])); else n_pass++;
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (log_b[zc[k]] !== 4'd0) $display("FAIL rr_gap c%0d got=%0d exp=0", zc[k], log_b[zc[k]]); else n_pass++;
    end
  endtask

  task automatic test_max_burst();
    int           gc [6] = '{1, 5, 6, 8, 9, 13};
    logic [N-1:0] gv [6] = '{3'b010, 3'b000, 3'b100, 3'b000, 3'b010, 3'b000};
    int           oc [10] = '{1, 2, 3, 4, 6, 7, 9, 10, 11, 12};
    int           os [10] = '{1, 1, 1, 1, 2, 2, 1, 1, 1, 1};
    int           oi [10] = '{0, 1, 2, 3, 0, 1, 4, 5, 6, 7};
    do_reset();
    load(1, 8, 0, 4'd8);
    load(2, 2, 'b10, 4'd8);
    run(14);
    for (int k = 0; k < 6; k++) begin
      n_checks++; if (log_g[gc[k]] !== gv[k]) $display("FAIL burst_grant c%0d got=%b exp=%b", gc[k], log_g[gc[k]], gv[k]); else n_pass++;
    end
    for (int k = 0; k < 10; k++) begin
      n_checks++; if (log_d[oc[k]] !== wd(os[k], oi[k]) || log_b[oc[k]] !== 4'd8)
        $display("FAIL burst_word c%0d got=%h/%0d exp=%h/8", oc[k], log_d[oc[k]], log_b[oc[k]], wd(os[k], oi[k]));
      else n_pass++;
    end
    n_checks++; if (log_b[5] !== 4'd0 || log_b[8] !== 4'd0 || log_b[13] !== 4'd0)
      $display("FAIL burst_gap got=%0d,%0d,%0d exp=0,0,0", log_b[5], log_b[8], log_b[13]);
    else n_pass++;
  endtask

  task automatic test_afull();
    do_reset();
    load(0, 4, 'b1000, 4'd8);
    for (int t = 0; t < 11; t++) tick(1'b1, (t >= 2 && t <= 6));
    n_checks++; if (log_b[1] !== 4'd8 || log_d[1] !== wd(0, 0)) $display("FAIL afull_first got=%h/%0d exp=%h/8", log_d[1], log_b[1], wd(0, 0)); else n_pass++;
    for (int k = 2; k <= 6; k++) begin
      n_checks++; if (log_r[k] !== 3'b000) $display("FAIL afull_ready c%0d got=%b exp=000", k, log_r[k]); else n_pass++;
      n_checks++; if (log_g[k] !== 3'b001) $display("FAIL afull_grant c%0d got=%b exp=001", k, log_g[k]); else n_pass++;
      n_checks++; if (log_b[k] !== 4'd0) $display("FAIL afull_tx_b c%0d got=%0d exp=0", k, log_b[k]); else n_pass++;
    end
    for (int k = 7; k <= 9; k++) begin
      n_checks++; if (log_b[k] !== 4'd8 || log_d[k] !== wd(0, k-6))
        $display("FAIL afull_resume c%0d got=%h/%0d exp=%h/8", k, log_d[k], log_b[k], wd(0, k-6));
      else n_pass++;
    end
    n_checks++; if (log_g[10] !== 3'b000) $display("FAIL afull_end_grant got=%b exp=000", log_g[10]); else n_pass++;
  endtask

  task automatic test_est_drop();
    do_reset();
    load(0, 4, 'b1000, 4'd8);
    load(1, 2, 'b10, 4'd8);
    for (int t = 0; t < 12; t++) tick(!(t == 2 || t == 3), 1'b0);
    n_checks++; if (log_r[2] !== 3'b000) $display("FAIL est_ready_drop got=%b exp=000", log_r[2]); else n_pass++;
    n_checks++; if (log_g[2] !== 3'b001) $display("FAIL est_grant_same got=%b exp=001", log_g[2]); else n_pass++;
    n_checks++; if (log_b[2] !== 4'd0) $display("FAIL est_tx_b got=%0d exp=0", log_b[2]); else n_pass++;
    n_checks++; if (log_g[3] !== 3'b000 || log_g[4] !== 3'b000) $display("FAIL est_idle got=%b,%b exp=000,000", log_g[3], log_g[4]); else n_pass++;
    n_checks++; if (log_g[5] !== 3'b001) $display("FAIL est_regrant got=%b exp=001", log_g[5]); else n_pass++;
    for (int k = 5; k <= 7; k++) begin
      n_checks++; if (log_b[k] !== 4'd8 || log_d[k] !== wd(0, k-4))
        $display("FAIL est_resume c%0d got=%h/%0d exp=%h/8", k, log_d[k], log_b[k], wd(0, k-4));
      else n_pass++;
    end
    n_checks++; if (log_g[9] !== 3'b010) $display("FAIL est_next_grant got=%b exp=010", log_g[9]); else n_pass++;
    n_checks++; if (log_d[10] !== wd(1, 1) || log_b[10] !== 4'd8) $display("FAIL est_next_word got=%h/%0d exp=%h/8", log_d[10], log_b[10], wd(1, 1)); else n_pass++;
  endtask

  task automatic test_bytes_and_reset();
    do_reset();
    load(0, 3, 'b100, 4'd8);
    s_bytes[0][0] = 4'd12;
    s_bytes[0][1] = 4'd0;
    s_bytes[0][2] = 4'd3;
    run(5);
    n_checks++; if (log_b[1] !== 4'd8) $display("FAIL bytes_clamp got=%0d exp=8", log_b[1]); else n_pass++;
    n_checks++; if (log_b[2] !== 4'd0) $display("FAIL bytes_zero got=%0d exp=0", log_b[2]); else n_pass++;
    n_checks++; if (log_b[3] !== 4'd3) $display("FAIL bytes_three got=%0d exp=3", log_b[3]); else n_pass++;
    n_checks++; if (log_d[3] !== wd(0, 2)) $display("FAIL bytes_last_d got=%h exp=%h", log_d[3], wd(0, 2)); else n_pass++;
    n_checks++; if (log_g[4] !== 3'b000) $display("FAIL bytes_end_grant got=%b exp=000", log_g[4]); else n_pass++;
    load(0, 4, 'b1000, 4'd8);
    run(2);
    drive_sources();
    #1;
    n_checks++; if (grant !== 3'b001 || tx_b !== 4'd8) $display("FAIL prerst_state got=%b/%0d exp=001/8", grant, tx_b); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (grant !== 3'b000) $display("FAIL rst_grant got=%b exp=000", grant); else n_pass++;
    n_checks++; if (req_ready !== 3'b000) $display("FAIL rst_ready got=%b exp=000", req_ready); else n_pass++;
    n_checks++; if (tx_b !== 4'd0 || tx_d !== 64'd0) $display("FAIL rst_tx got=%h/%0d exp=0/0", tx_d, tx_b); else n_pass++;
    #10;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_fairness();
    test_max_burst();
    test_afull();
    test_est_drop();
    test_bytes_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
